// File: rtl/pcpi_arb_pkg.sv
// Shared definitions for the two-requester PCPI multiplier arbiter:
// opcode constants, FSM states and the MUL-class instruction decode.
package pcpi_arb_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // funct3 000..011 (MUL, MULH, MULHSU, MULHU); bit 14 set means DIV/REM
  function automatic logic is_mul(input logic [31:0] insn);
    return (insn[6:0] == OPC_OP) && (insn[31:25] == F7_MULDIV) && !insn[14];
  endfunction

endpackage

// File: rtl/pcpi_mul_decode.sv
// Combinational MUL-class pre-decode for one PCPI requester.
module pcpi_mul_decode
  import pcpi_arb_pkg::*;
(
  input  logic [31:0] insn,
  output logic        is_mul
);

  assign is_mul = pcpi_arb_pkg::is_mul(insn);

endmodule

// File: rtl/pcpi_mul_arbiter.sv
// Round-robin sharing of one PCPI multiplier between two PCPI requesters,
// with latched operands, combinational return path and a latency timeout.
module pcpi_mul_arbiter
  import pcpi_arb_pkg::*;
#(
  parameter int unsigned MAX_LAT = 80,
  parameter int unsigned CNT_W   = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s0_valid,
  input  logic [31:0] s0_insn,
  input  logic [31:0] s0_rs1,
  input  logic [31:0] s0_rs2,
  output logic        s0_wr,
  output logic [31:0] s0_rd,
  output logic        s0_wait,
  output logic        s0_ready,
  output logic        s0_abort,
  input  logic        s1_valid,
  input  logic [31:0] s1_insn,
  input  logic [31:0] s1_rs1,
  input  logic [31:0] s1_rs2,
  output logic        s1_wr,
  output logic [31:0] s1_rd,
  output logic        s1_wait,
  output logic        s1_ready,
  output logic        s1_abort,
  output logic        m_valid,
  output logic [31:0] m_insn,
  output logic [31:0] m_rs1,
  output logic [31:0] m_rs2,
  input  logic        m_wr,
  input  logic [31:0] m_rd,
  input  logic        m_wait,
  input  logic        m_ready
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t            state;
  logic              gnt;
  logic              last;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       insn_q;
  logic [31:0]       rs1_q;
  logic [31:0]       rs2_q;

  logic dec0, dec1, req0, req1, pick;
  logic busy, drain, timeout, live, rdy0, rdy1;
  logic unused_m_wait;

  pcpi_mul_decode u_dec0 (.insn(s0_insn), .is_mul(dec0));
  pcpi_mul_decode u_dec1 (.insn(s1_insn), .is_mul(dec1));

  assign req0  = s0_valid & dec0;
  assign req1  = s1_valid & dec1;
  assign busy  = (state == BUSY);
  assign drain = (state == DRAIN);
  assign pick  = (req0 & req1) ? ~last : req1;

  // m_ready has priority: a completing op in the final cycle is not aborted
  assign timeout = busy & ~m_ready & (cnt == CNT_LAST);

  assign unused_m_wait = m_wait;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      gnt    <= 1'b0;
      last   <= 1'b1;
      cnt    <= '0;
      insn_q <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            gnt    <= pick;
            insn_q <= pick ? s1_insn : s0_insn;
            rs1_q  <= pick ? s1_rs1  : s0_rs1;
            rs2_q  <= pick ? s1_rs2  : s0_rs2;
            cnt    <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          if (m_ready || (cnt == CNT_LAST)) begin
            last  <= gnt;
            state <= DRAIN;
          end
        end
        DRAIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are forced low while reset is asserted, even if state is still BUSY
  always_comb begin
    live     = ~reset;
    rdy0     = live & busy & ~gnt & m_ready;
    rdy1     = live & busy &  gnt & m_ready;

    m_valid  = live & busy;
    m_insn   = live ? insn_q : '0;
    m_rs1    = live ? rs1_q  : '0;
    m_rs2    = live ? rs2_q  : '0;

    s0_ready = rdy0;
    s0_wr    = rdy0 & m_wr;
    s0_rd    = (live & ~gnt) ? m_rd : '0;
    s0_abort = live & timeout & ~gnt;
    s0_wait  = live & req0 & ~rdy0 & ~(drain & ~last);

    s1_ready = rdy1;
    s1_wr    = rdy1 & m_wr;
    s1_rd    = (live & gnt) ? m_rd : '0;
    s1_abort = live & timeout & gnt;
    s1_wait  = live & req1 & ~rdy1 & ~(drain & last);
  end

endmodule
